keccak_rho_stage: RTL

//   Registered, parametrised Keccak rho step for any legal lane width w = LANE_W.

---
 rtl/keccak_rho_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/keccak_rho_stage.sv
// ============================================================================
// Module   : keccak_rho_stage
// Brief    : Registered Keccak rho step (optionally merged with pi when
//            KECCAK_PI_EN is defined) behind a 2-entry valid/ready buffer
//            that tags each block with its permutation round index.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keccak_rho_stage #(
    parameter int LANE_W  = 64,
    parameter int STATE_W = 25 * LANE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] inData,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] outData,
    output logic [4:0]         out_round,
    output logic               out_last
);

    localparam int         NR           = 12 + 2 * $clog2(LANE_W);
    localparam logic [4:0] c_last_round = 5'(NR - 1);

    function automatic int rho_raw(input int idx);
        case (idx)
            0:  return 0;    1:  return 1;    2:  return 190;  3:  return 28;
            4:  return 91;   5:  return 36;   6:  return 300;  7:  return 6;
            8:  return 55;   9:  return 276;  10: return 3;    11: return 10;
            12: return 171;  13: return 153;  14: return 231;  15: return 105;
            16: return 45;   17: return 15;   18: return 21;   19: return 136;
            20: return 210;  21: return 66;   22: return 253;  23: return 120;
            default: return 78;
        endcase
    endfunction

    logic [STATE_W-1:0] w_rot;

    // Pure wiring: every output bit is a fixed input bit chosen at elaboration.
    for (genvar i = 0; i < 25; i++) begin : g_lane
`ifdef KECCAK_PI_EN
        localparam int c_src = 5 * (i % 5) + (((i % 5) + 3 * (i / 5)) % 5);
`else
        localparam int c_src = i;
`endif
        localparam int c_rot = rho_raw(c_src) % LANE_W;
        for (genvar z = 0; z < LANE_W; z++) begin : g_bit
            assign w_rot[LANE_W*i + z] =
                inData[LANE_W*c_src + ((z - c_rot + LANE_W) % LANE_W)];
        end
    end

    logic [1:0]         r_count;
    logic               r_in_ready;
    logic [4:0]         r_round;
    logic [STATE_W-1:0] r_head_data;
    logic [4:0]         r_head_round;
    logic               r_head_last;
    logic [STATE_W-1:0] r_tail_data;
    logic [4:0]         r_tail_round;
    logic               r_tail_last;

    logic w_push;
    logic w_pop;
    logic w_tag_last;

    assign w_push     = in_valid & r_in_ready;
    assign w_pop      = (r_count != 2'd0) & out_ready;
    assign w_tag_last = (r_round == c_last_round);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= 2'd0;
            r_in_ready   <= 1'b1;
            r_round      <= 5'd0;
            r_head_data  <= '0;
            r_head_round <= 5'd0;
            r_head_last  <= 1'b0;
            r_tail_data  <= '0;
            r_tail_round <= 5'd0;
            r_tail_last  <= 1'b0;
        end else if (flush) begin
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
            r_round    <= 5'd0;
        end else begin
            if (w_push) begin
                r_round <= w_tag_last ? 5'd0 : r_round + 5'd1;
            end
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head_data  <= w_rot;
                        r_head_round <= r_round;
                        r_head_last  <= w_tag_last;
                        r_count      <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head_data  <= w_rot;
                        r_head_round <= r_round;
                        r_head_last  <= w_tag_last;
                    end else if (w_push) begin
                        r_tail_data  <= w_rot;
                        r_tail_round <= r_round;
                        r_tail_last  <= w_tag_last;
                        r_count      <= 2'd2;
                        r_in_ready   <= 1'b0;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a pop can happen here.
                    if (w_pop) begin
                        r_head_data  <= r_tail_data;
                        r_head_round <= r_tail_round;
                        r_head_last  <= r_tail_last;
                        r_count      <= 2'd1;
                        r_in_ready   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign outData   = r_head_data;
    assign out_round = r_head_round;
    assign out_last  = r_head_last;

endmodule

`default_nettype wire
